instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
//  Fetch-side front end that feeds the IF/ID pipeline register of the LEGv8 pipeline.
//  Issues in-order word fetches to instruction memory over a req/resp interface.
//  Buffers up to DEPTH {pc, instruction} pairs and presents them with valid/ready.
//  Discards wrong-path fetches on a branch redirect from the EX/MEM stage.
// PARAMETERS
//  DEPTH     4   number of queue slots; power of 2, >= 2
//  PC_W      64  PC / address width
//  INSTR_W   32  instruction width
// PORTS
//  CLK             in   1        clock; all state updates on posedge
//  resetl          in   1        asynchronous, active-low reset
//  startpc         in   PC_W     fetch PC loaded during reset; must be stable while resetl=0
//  redirect_valid  in   1        branch taken / uncond branch: flush and refetch
//  redirect_pc     in   PC_W     new fetch PC; bits [1:0] ignored (forced 0)
//  imem_req_valid  out  1        fetch request
//  imem_req_ready  in   1        memory accepts request
//  imem_req_addr   out  PC_W     fetch address
//  imem_resp_valid in   1        response beat; responses return in request order
//  imem_resp_data  in   INSTR_W  fetched instruction
//  out_valid       out  1        head slot holds a filled instruction
//  out_ready       in   1        consumer accepts (IF/ID write enable)
//  out_pc          out  PC_W     PC of head instruction
//  out_instr       out  INSTR_W  head instruction
//  occupancy       out  $clog2(DEPTH+1)  slots allocated (filled + pending)
// BEHAVIOUR
//  - Reset (resetl=0, async): fetch_pc<=startpc; all slots empty; in_flight=0; discard=0;
//    imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0, occupancy=0.
//  - Slot allocated at request handshake (req_valid&req_ready), tagged with fetch_pc, marked pending.
//  - imem_req_valid = resetl & ~redirect_valid & (occupancy < DEPTH); imem_req_addr = fetch_pc.
//  - On request handshake: fetch_pc <= fetch_pc + 4 (mod 2^PC_W, wraps silently).
//  - Response with discard==0 fills the oldest pending slot; with discard>0 it is dropped and
//    discard decrements. A response with no pending slot and discard==0 is a protocol error (ignored).
//  - out_valid = head slot filled. Pop on out_valid & out_ready; head advances, wraps mod DEPTH.
//  - Min latency: response in cycle N -> out_valid in cycle N+1. Full throughput 1 instr/cycle.
//  - Full (occupancy==DEPTH): req_valid low; pop and a new request in the same cycle are both
//    allowed only from the next cycle (request gating uses registered occupancy).
//  - Empty: out_valid=0; out_pc/out_instr hold last value.
//  - Redirect (highest priority): all slots cleared, occupancy<=0, fetch_pc<={redirect_pc[PC_W-1:2],2'b00},
//    discard <= discard + in_flight - (resp fire this cycle ? 1 : 0); no request issued that cycle.
//    A pop in the same cycle counts as consumed; a response in that cycle is dropped.
//  - in_flight = requests issued minus responses received; never exceeds DEPTH + discard backlog.
//  - Redirect with discard>0 outstanding accumulates; new-path fetches fill only after all dropped.
//  - Reset mid-operation: all state returns to reset values immediately; late responses after
//    reset release are NOT tracked (memory must be reset together with this block).
// CONFIGURATION
//  PFQ_STATS_EN defined: adds outputs stat_redirects[31:0] (redirect_valid cycles) and
//    stat_dropped[31:0] (responses discarded); both saturate at 32'hFFFFFFFF, reset to 0.
//  PFQ_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 reset startpc=0x1000, mem 1-cycle, out_ready=1 -> out_pc 0x1000,0x1004,0x1008 on
//    consecutive cycles, instr matches memory image.
//  2 out_ready=0, req_ready=1 -> exactly 4 requests (0x1000..0x100C), occupancy=4, req_valid=0;
//    out_ready=1 -> four pops in order, fetching resumes at 0x1010.
//  3 mem latency 3, redirect_pc=0x2002 while 2 in flight -> 2 responses dropped, next out_pc=0x2000,
//    stat_dropped=2 when PFQ_STATS_EN.
//  4 redirect same cycle as response and pop -> popped item consumed, response dropped,
//    no req_valid that cycle, occupancy=0 next cycle.
//  5 startpc=64'hFFFF_FFFF_FFFF_FFF8 -> fetches ...FFF8, ...FFFC, 0x0 (wrap).
//  6 assert resetl=0 mid-stream with 3 slots filled -> out_valid=0, occupancy=0 asynchronously.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: in-order word fetch into a DEPTH-slot {pc, instr} ring, flushed on redirect.
// Latency: a response in cycle N is presented on out_valid in cycle N+1; sustains 1 instr/cycle.
// Backpressure: out_ready low holds the head; fetch stops while all DEPTH slots are allocated.
// Optional macro PFQ_STATS_EN adds saturating stat_redirects / stat_dropped counters.
module instr_prefetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               resetl,
  input  logic [PC_W-1:0]    startpc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   occupancy
`ifdef PFQ_STATS_EN
  ,
  output logic [31:0]        stat_redirects,
  output logic [31:0]        stat_dropped
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  // Wrong-path backlog can exceed DEPTH when redirects arrive faster than memory drains.
  localparam int DISC_W = CNT_W + 4;

  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    slot_pc    [DEPTH];
  logic [INSTR_W-1:0] slot_instr [DEPTH];
  logic [DEPTH-1:0]   slot_filled;
  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic [PTR_W-1:0]   fill_ptr;
  logic [CNT_W-1:0]   occ;
  logic [CNT_W-1:0]   live;      // allocated slots still waiting for their response
  logic [DISC_W-1:0]  discard;   // outstanding wrong-path responses to drop
  logic [PC_W-1:0]    held_pc;
  logic [INSTR_W-1:0] held_instr;

  logic               req_fire;
  logic               head_filled;
  logic               pop;
  logic               resp_drop;
  logic               resp_fill;
  logic [DEPTH-1:0]   fill_mask;
  logic [DEPTH-1:0]   pop_mask;
  logic [DISC_W-1:0]  disc_total;

  assign imem_req_valid = resetl & ~redirect_valid & (occ < CNT_W'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign head_filled    = slot_filled[head_ptr];
  assign pop            = head_filled & out_ready;
  assign resp_drop      = imem_resp_valid & (redirect_valid | (discard != '0));
  assign resp_fill      = imem_resp_valid & ~redirect_valid & (discard == '0) & (live != '0);

  assign out_valid      = head_filled;
  assign out_pc         = head_filled ? slot_pc[head_ptr]    : held_pc;
  assign out_instr      = head_filled ? slot_instr[head_ptr] : held_instr;
  assign occupancy      = occ;

  // Per-slot set/clear masks and the backlog a redirect leaves behind.
  always_comb begin
    fill_mask  = '0;
    pop_mask   = '0;
    disc_total = discard + DISC_W'(live);
    if (resp_fill) fill_mask[fill_ptr] = 1'b1;
    if (pop)       pop_mask[head_ptr]  = 1'b1;
    if (imem_resp_valid && disc_total != '0) disc_total = disc_total - DISC_W'(1);
  end

  // Slot payload storage; validity lives in slot_filled, so no reset is needed here.
  always_ff @(posedge CLK) begin
    if (req_fire)  slot_pc[tail_ptr]    <= fetch_pc;
    if (resp_fill) slot_instr[fill_ptr] <= imem_resp_data;
  end

  // Queue control: pointers, occupancy, in-flight accounting and redirect flush.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      fetch_pc    <= startpc;
      head_ptr    <= '0;
      tail_ptr    <= '0;
      fill_ptr    <= '0;
      slot_filled <= '0;
      occ         <= '0;
      live        <= '0;
      discard     <= '0;
      held_pc     <= '0;
      held_instr  <= '0;
    end else begin
      if (head_filled) begin
        held_pc    <= slot_pc[head_ptr];
        held_instr <= slot_instr[head_ptr];
      end
      if (redirect_valid) begin
        fetch_pc    <= redirect_pc & {{(PC_W-2){1'b1}}, 2'b00};
        head_ptr    <= '0;
        tail_ptr    <= '0;
        fill_ptr    <= '0;
        slot_filled <= '0;
        occ         <= '0;
        live        <= '0;
        discard     <= disc_total;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + PC_W'(4);
          tail_ptr <= tail_ptr + PTR_W'(1);
        end
        if (resp_fill) fill_ptr <= fill_ptr + PTR_W'(1);
        if (pop)       head_ptr <= head_ptr + PTR_W'(1);
        if (imem_resp_valid && discard != '0) discard <= discard - DISC_W'(1);
        slot_filled <= (slot_filled | fill_mask) & ~pop_mask;
        occ         <= occ + CNT_W'(req_fire) - CNT_W'(pop);
        live        <= live + CNT_W'(req_fire) - CNT_W'(resp_fill);
      end
    end
  end

`ifdef PFQ_STATS_EN
  // Saturating event counters for redirect cycles and dropped responses.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      stat_redirects <= '0;
      stat_dropped   <= '0;
    end else begin
      if (redirect_valid && stat_redirects != 32'hFFFF_FFFF) stat_redirects <= stat_redirects + 32'd1;
      if (resp_drop && stat_dropped != 32'hFFFF_FFFF)        stat_dropped   <= stat_dropped + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with an in-order, fixed-latency memory model.
// Memory image: instr(addr) = addr[31:0] ^ 32'hD503_0000.
module tb_instr_prefetch_queue;

  logic        CLK = 1'b0;
  logic        resetl;
  logic [63:0] startpc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data  = 32'h0;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  occupancy;
`ifdef PFQ_STATS_EN
  logic [31:0] stat_redirects;
  logic [31:0] stat_dropped;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int lat         = 1;

  logic [63:0] mq_addr[$];
  int          mq_due[$];
  logic [63:0] req_log[$];
  int          req_cyc[$];
  logic [63:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  int          pop_cyc[$];

  instr_prefetch_queue #(.DEPTH(4), .PC_W(64), .INSTR_W(32)) dut (
    .CLK            (CLK),
    .resetl         (resetl),
    .startpc        (startpc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .occupancy      (occupancy)
`ifdef PFQ_STATS_EN
    ,
    .stat_redirects (stat_redirects),
    .stat_dropped   (stat_dropped)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] image(input logic [63:0] a);
    return a[31:0] ^ 32'hD503_0000;
  endfunction

  // Edge monitor: memory request capture, response retirement, pop log, cycle count.
  always @(posedge CLK) begin
    if (!resetl) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (imem_resp_valid && mq_addr.size() > 0) begin
        mq_addr.delete(0);
        mq_due.delete(0);
      end
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat);
        req_log.push_back(imem_req_addr);
        req_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        pop_pc.push_back(out_pc);
        pop_instr.push_back(out_instr);
        pop_cyc.push_back(cyc);
      end
    end
    cyc = cyc + 1;
  end

  // Memory response driver: present the oldest request once its latency has elapsed.
  always @(negedge CLK) begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    if (resetl && mq_due.size() > 0) begin
      if (mq_due[0] <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = image(mq_addr[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1);
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_cyc.delete();
    pop_pc.delete();
    pop_instr.delete();
    pop_cyc.delete();
  endtask

  // Leaves resetl rising 1 time unit after a posedge; that cycle is the first fetch cycle.
  task automatic apply_reset(input logic [63:0] pc);
    clk_n(1);
    startpc        = pc;
    redirect_valid = 1'b0;
    resetl         = 1'b0;
    clk_n(2);
    clear_logs();
    resetl = 1'b1;
  endtask

  task automatic test_reset();
    resetl         = 1'b0;
    startpc        = 64'h1000;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    clk_n(3);
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_pc !== 64'h0) begin miscompares++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    vectors++; if (occupancy !== 3'd0) begin miscompares++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    vectors++; if (imem_req_addr !== 64'h1000) begin miscompares++; $display("FAIL reset_req_addr: got %h want 1000", imem_req_addr); end
  endtask

  task automatic test_stream();
    logic [63:0] exp_pc[3];
    logic [31:0] exp_in[3];
    exp_pc = '{64'h1000, 64'h1004, 64'h1008};
    exp_in = '{32'hD503_1000, 32'hD503_1004, 32'hD503_1008};
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    apply_reset(64'h1000);
    clk_n(10);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (pop_pc.size() <= i) begin miscompares++; $display("FAIL stream_pop[%0d]: got none want pc %h", i, exp_pc[i]); end
      else if (pop_pc[i] !== exp_pc[i] || pop_instr[i] !== exp_in[i]) begin
        miscompares++; $display("FAIL stream_pop[%0d]: got %h/%h want %h/%h", i, pop_pc[i], pop_instr[i], exp_pc[i], exp_in[i]);
      end
    end
    vectors++;
    if (pop_cyc.size() < 3 || req_cyc.size() < 1) begin miscompares++; $display("FAIL stream_timing: got %0d pops want >=3", pop_cyc.size()); end
    else if (pop_cyc[0] - req_cyc[0] != 2 || pop_cyc[1] != pop_cyc[0] + 1 || pop_cyc[2] != pop_cyc[1] + 1) begin
      miscompares++; $display("FAIL stream_timing: got req@%0d pops@%0d,%0d,%0d want pops at req+2,+3,+4", req_cyc[0], pop_cyc[0], pop_cyc[1], pop_cyc[2]);
    end
  endtask

  task automatic test_full_backpressure();
    logic [63:0] exp_pc[4];
    exp_pc = '{64'h1000, 64'h1004, 64'h1008, 64'h100C};
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
    apply_reset(64'h1000);
    clk_n(8);
    vectors++; if (req_log.size() != 4) begin miscompares++; $display("FAIL full_req_count: got %0d want 4", req_log.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (req_log.size() <= i) begin miscompares++; $display("FAIL full_req[%0d]: got none want %h", i, exp_pc[i]); end
      else if (req_log[i] !== exp_pc[i]) begin miscompares++; $display("FAIL full_req[%0d]: got %h want %h", i, req_log[i], exp_pc[i]); end
    end
    vectors++; if (occupancy !== 3'd4) begin miscompares++; $display("FAIL full_occupancy: got %0d want 4", occupancy); end
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_req_valid: got %b want 0", imem_req_valid); end
    vectors++; if (out_valid !== 1'b1 || out_pc !== 64'h1000) begin miscompares++; $display("FAIL full_head: got %b/%h want 1/1000", out_valid, out_pc); end
    out_ready = 1'b1;
    #1;
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_pop_cycle_req: got %b want 0", imem_req_valid); end
    clk_n(1);
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1010 || occupancy !== 3'd3) begin
      miscompares++; $display("FAIL full_resume: got %b/%h/%0d want 1/1010/3", imem_req_valid, imem_req_addr, occupancy);
    end
    clk_n(8);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (pop_pc.size() <= i) begin miscompares++; $display("FAIL full_pop[%0d]: got none want %h", i, exp_pc[i]); end
      else if (pop_pc[i] !== exp_pc[i]) begin miscompares++; $display("FAIL full_pop[%0d]: got %h want %h", i, pop_pc[i], exp_pc[i]); end
    end
    vectors++;
    if (req_log.size() < 5) begin miscompares++; $display("FAIL full_req_next: got %0d requests want >=5", req_log.size()); end
    else if (req_log[4] !== 64'h1010) begin miscompares++; $display("FAIL full_req_next: got %h want 1010", req_log[4]); end
  endtask

  task automatic test_redirect_drop();
    logic [63:0] exp_req[3];
    exp_req = '{64'h1000, 64'h1004, 64'h2000};
    lat = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
    apply_reset(64'h1000);
    clk_n(2);
    redirect_valid = 1'b1; redirect_pc = 64'h2002;
    #1;
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL drop_redirect_req: got %b want 0", imem_req_valid); end
    clk_n(1);
    redirect_valid = 1'b0;
    clk_n(12);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (req_log.size() <= i) begin miscompares++; $display("FAIL drop_req[%0d]: got none want %h", i, exp_req[i]); end
      else if (req_log[i] !== exp_req[i]) begin miscompares++; $display("FAIL drop_req[%0d]: got %h want %h", i, req_log[i], exp_req[i]); end
    end
    vectors++;
    if (pop_pc.size() < 2) begin miscompares++; $display("FAIL drop_pop: got %0d pops want >=2", pop_pc.size()); end
    else if (pop_pc[0] !== 64'h2000 || pop_instr[0] !== 32'hD503_2000 || pop_pc[1] !== 64'h2004) begin
      miscompares++; $display("FAIL drop_pop: got %h/%h,%h want 2000/d5032000,2004", pop_pc[0], pop_instr[0], pop_pc[1]);
    end
`ifdef PFQ_STATS_EN
    vectors++; if (stat_dropped !== 32'd2) begin miscompares++; $display("FAIL drop_stat_dropped: got %0d want 2", stat_dropped); end
    vectors++; if (stat_redirects !== 32'd1) begin miscompares++; $display("FAIL drop_stat_redirects: got %0d want 1", stat_redirects); end
`endif
  endtask

  task automatic test_redirect_collide();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    apply_reset(64'h1000);
    clk_n(2);
    vectors++; if (out_valid !== 1'b1 || out_pc !== 64'h1000) begin miscompares++; $display("FAIL collide_head: got %b/%h want 1/1000", out_valid, out_pc); end
    redirect_valid = 1'b1; redirect_pc = 64'h3000;
    #1;
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL collide_req_valid: got %b want 0", imem_req_valid); end
    clk_n(1);
    redirect_valid = 1'b0;
    vectors++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL collide_flush: got occ %0d valid %b want 0/0", occupancy, out_valid); end
    vectors++; if (out_pc !== 64'h1000 || out_instr !== 32'hD503_1000) begin miscompares++; $display("FAIL collide_hold: got %h/%h want 1000/d5031000", out_pc, out_instr); end
    clk_n(8);
    vectors++;
    if (pop_pc.size() < 2 || req_log.size() < 3) begin miscompares++; $display("FAIL collide_seq: got %0d pops %0d reqs want >=2/>=3", pop_pc.size(), req_log.size()); end
    else if (pop_pc[0] !== 64'h1000 || pop_pc[1] !== 64'h3000 || pop_instr[1] !== 32'hD503_3000 || req_log[2] !== 64'h3000) begin
      miscompares++; $display("FAIL collide_seq: got pops %h,%h/%h req2 %h want 1000,3000/d5033000 req2 3000", pop_pc[0], pop_pc[1], pop_instr[1], req_log[2]);
    end
`ifdef PFQ_STATS_EN
    vectors++; if (stat_dropped !== 32'd1) begin miscompares++; $display("FAIL collide_stat_dropped: got %0d want 1", stat_dropped); end
`endif
  endtask

  task automatic test_wrap();
    logic [63:0] exp_pc[3];
    exp_pc = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    apply_reset(64'hFFFF_FFFF_FFFF_FFF8);
    clk_n(8);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (req_log.size() <= i) begin miscompares++; $display("FAIL wrap_req[%0d]: got none want %h", i, exp_pc[i]); end
      else if (req_log[i] !== exp_pc[i]) begin miscompares++; $display("FAIL wrap_req[%0d]: got %h want %h", i, req_log[i], exp_pc[i]); end
    end
    vectors++;
    if (pop_pc.size() < 3) begin miscompares++; $display("FAIL wrap_pop: got %0d pops want >=3", pop_pc.size()); end
    else if (pop_instr[0] !== 32'h2AFC_FFF8 || pop_pc[2] !== 64'h0 || pop_instr[2] !== 32'hD503_0000) begin
      miscompares++; $display("FAIL wrap_pop: got %h,%h/%h want 2afcfff8,0/d5030000", pop_instr[0], pop_pc[2], pop_instr[2]);
    end
  endtask

  task automatic test_async_reset();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
    apply_reset(64'h1000);
    clk_n(4);
    vectors++; if (out_valid !== 1'b1 || occupancy !== 3'd4) begin miscompares++; $display("FAIL areset_pre: got %b/%0d want 1/4", out_valid, occupancy); end
    #2;
    resetl = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin miscompares++; $display("FAIL areset_now: got %b/%0d want 0/0", out_valid, occupancy); end
    vectors++; if (imem_req_valid !== 1'b0 || out_pc !== 64'h0) begin miscompares++; $display("FAIL areset_outs: got %b/%h want 0/0", imem_req_valid, out_pc); end
    clk_n(2);
    clear_logs();
    out_ready = 1'b1;
    resetl = 1'b1;
    clk_n(5);
    vectors++;
    if (req_log.size() < 1 || pop_pc.size() < 1) begin miscompares++; $display("FAIL areset_restart: got %0d reqs %0d pops want >=1", req_log.size(), pop_pc.size()); end
    else if (req_log[0] !== 64'h1000 || pop_pc[0] !== 64'h1000) begin miscompares++; $display("FAIL areset_restart: got %h/%h want 1000/1000", req_log[0], pop_pc[0]); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_backpressure();
    test_redirect_drop();
    test_redirect_collide();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
